// File: rtl/alu_seq_pkg.sv
// Shared definitions for alu_seq: byte-ALU op codes and sequencer state.
package alu_seq_pkg;

  localparam logic [2:0] ADD   = 3'b000;
  localparam logic [2:0] SUB   = 3'b001;
  localparam logic [2:0] SUBA  = 3'b010;
  localparam logic [2:0] OR    = 3'b011;
  localparam logic [2:0] AND   = 3'b100;
  localparam logic [2:0] NOTAB = 3'b101;
  localparam logic [2:0] XOR   = 3'b110;
  localparam logic [2:0] XNOR  = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic op_is_arith(input logic [2:0] op);
    return (op == ADD) || (op == SUB) || (op == SUBA);
  endfunction

endpackage

// File: rtl/alu_seq.sv
// Byte-serial sequencer driving an external 8-bit ALU over NBYTES-wide operands.
// Optional ALU_SEQ_FLAGS_EN adds registered res_zero / res_neg outputs.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [2:0]          req_op,
  input  logic [8*NBYTES-1:0] req_a,
  input  logic [8*NBYTES-1:0] req_b,
  input  logic                req_cin,
  output logic [0:2]          alu_oper,
  output logic [8:1]          alu_a,
  output logic [8:1]          alu_b,
  output logic                alu_c_in,
  input  logic [8:1]          alu_sum,
  input  logic                alu_c_out,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [8*NBYTES-1:0] res,
  output logic                res_c_out
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic                res_zero,
  output logic                res_neg
`endif
);

  localparam int W  = 8*NBYTES;
  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES-1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    op_q;
  logic [W-1:0]  a_q, b_q;
  logic          cin_q;
  logic          carry_q;
  logic [W-1:0]  res_nxt;
  logic          run;

  assign run       = (state == RUN);
  assign req_ready = (state == IDLE);
  assign res_valid = (state == DONE);

  // ALU port drive; forced to zero whenever the sequencer is not running.
  always_comb begin
    alu_oper = '0;
    alu_a    = '0;
    alu_b    = '0;
    alu_c_in = 1'b0;
    if (run) begin
      alu_oper = op_q;
      alu_a    = a_q[cnt*8 +: 8];
      alu_b    = b_q[cnt*8 +: 8];
      if (cnt == '0)
        alu_c_in = op_is_arith(op_q) & cin_q;
      else if ((op_q == ADD) || (op_q == SUB))
        alu_c_in = carry_q;
      else if (op_q == SUBA)
        // the ALU inverts c_in for this op, so hand back the inverted carry
        alu_c_in = ~carry_q;
    end
  end

  always_comb begin
    res_nxt               = res;
    res_nxt[cnt*8 +: 8]   = alu_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      carry_q   <= 1'b0;
      res       <= '0;
      res_c_out <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      res_zero  <= 1'b0;
      res_neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q  <= req_op;
            a_q   <= req_a;
            b_q   <= req_b;
            cin_q <= req_cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res     <= res_nxt;
          carry_q <= alu_c_out;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt       <= '0;
            res_c_out <= op_is_arith(op_q) & alu_c_out;
`ifdef ALU_SEQ_FLAGS_EN
            res_zero  <= (res_nxt == '0);
            res_neg   <= res_nxt[W-1];
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (NBYTES=4) with a combinational byte-ALU model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic        req_cin = 1'b0;
  logic [0:2]  alu_oper;
  logic [8:1]  alu_a, alu_b, alu_sum;
  logic        alu_c_in, alu_c_out;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res;
  logic        res_c_out;
`ifdef ALU_SEQ_FLAGS_EN
  logic        res_zero, res_neg;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  alu_seq #(.NBYTES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
    .alu_oper(alu_oper), .alu_a(alu_a), .alu_b(alu_b), .alu_c_in(alu_c_in),
    .alu_sum(alu_sum), .alu_c_out(alu_c_out),
    .res_valid(res_valid), .res_ready(res_ready), .res(res), .res_c_out(res_c_out)
`ifdef ALU_SEQ_FLAGS_EN
    , .res_zero(res_zero), .res_neg(res_neg)
`endif
  );

  // external 8-bit ALU
  always_comb begin
    {alu_c_out, alu_sum} = 9'h0;
    case (alu_oper)
      ADD:   {alu_c_out, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_c_in};
      SUB:   {alu_c_out, alu_sum} = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'b0, alu_c_in};
      SUBA:  {alu_c_out, alu_sum} = {1'b0, alu_b} + {1'b0, ~alu_a} + {8'b0, ~alu_c_in};
      OR:    alu_sum = alu_a | alu_b;
      AND:   alu_sum = alu_a & alu_b;
      NOTAB: alu_sum = ~alu_a & alu_b;
      XOR:   alu_sum = alu_a ^ alu_b;
      XNOR:  alu_sum = ~(alu_a ^ alu_b);
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // whole-word reference: result and final carry of the 32-bit operation
  function automatic void model(input logic [2:0] op, input logic [31:0] a, b, input logic cin,
                                output logic [31:0] r, output logic c);
    logic [31:0] na, nb;
    logic [63:0] s;
    na = ~a;
    nb = ~b;
    s  = '0;
    case (op)
      3'd0: s = 64'(a) + 64'(b) + 64'(cin);
      3'd1: s = 64'(a) + 64'(nb) + 64'(cin);
      3'd2: s = 64'(b) + 64'(na) + 64'(!cin);
      3'd3: s = 64'(a | b);
      3'd4: s = 64'(a & b);
      3'd5: s = 64'(na & b);
      3'd6: s = 64'(a ^ b);
      default: s = 64'(~(a ^ b));
    endcase
    r = s[31:0];
    c = (op <= 3'd2) ? s[32] : 1'b0;
  endfunction

  // carry the sequencer should present to the ALU when working on byte k
  function automatic logic exp_cin(input logic [2:0] op, input logic [31:0] a, b,
                                   input logic cin, input int k);
    logic [63:0] m, s, a64, b64;
    if (op > 3'd2) return 1'b0;
    if (k == 0) return cin;
    m   = (64'd1 << (8*k)) - 64'd1;
    a64 = 64'(a);
    b64 = 64'(b);
    case (op)
      3'd0:    s = (a64 & m) + (b64 & m) + 64'(cin);
      3'd1:    s = (a64 & m) + (~b64 & m) + 64'(cin);
      default: s = (b64 & m) + (~a64 & m) + 64'(!cin);
    endcase
    return (op == 3'd2) ? !s[8*k] : s[8*k];
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_wait", req_ready, 1);
  endtask

  task automatic run_txn(input logic [2:0] op, input logic [31:0] a, b, input logic cin,
                         input int stall);
    logic [31:0] er;
    logic        ec;
    model(op, a, b, cin, er, ec);
    wait_ready();
    req_op = op; req_a = a; req_b = b; req_cin = cin; req_valid = 1'b1;
    @(posedge clk); #1;
    // scramble inputs after accept; they must not matter
    req_valid = 1'b0;
    req_op = 3'($urandom); req_a = $urandom; req_b = $urandom; req_cin = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("run_res_valid", res_valid, 0);
      chk("run_alu_oper", alu_oper, op);
      chk("run_alu_a", alu_a, a[k*8 +: 8]);
      chk("run_alu_b", alu_b, b[k*8 +: 8]);
      chk("run_alu_c_in", alu_c_in, exp_cin(op, a, b, cin, k));
    end
    @(posedge clk); #1;
    chk("done_valid", res_valid, 1);
    chk("done_res", res, er);
    chk("done_c_out", res_c_out, ec);
    chk("done_req_ready", req_ready, 0);
`ifdef ALU_SEQ_FLAGS_EN
    chk("done_zero", res_zero, er == 0);
    chk("done_neg", res_neg, er[31]);
`endif
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", res_valid, 1);
      chk("stall_res", res, er);
      chk("stall_c_out", res_c_out, ec);
      chk("stall_req_ready", req_ready, 0);
      chk("stall_alu_a", alu_a, 0);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    chk("ack_valid", res_valid, 0);
    chk("ack_req_ready", req_ready, 1);
    chk("ack_res_hold", res, er);
  endtask

  initial begin
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_c_out", res_c_out, 0);
    chk("rst_alu", {alu_oper, alu_a, alu_b, alu_c_in}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run_txn(3'b001, 32'h0000_0005, 32'h0000_0003, 1'b1, 0);
    run_txn(3'b010, 32'h0000_0003, 32'h0000_0005, 1'b1, 0);
    run_txn(3'b001, 32'h0000_0000, 32'h0000_0001, 1'b1, 0);
    run_txn(3'b110, 32'hA5A5_A5A5, 32'hFFFF_0000, 1'b1, 3);

    // reset while byte 2 is on the ALU
    wait_ready();
    req_op = 3'b000; req_a = 32'h1234_5678; req_b = 32'h1111_1111; req_cin = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_alu_a", alu_a, 8'h34);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_res", res, 0);
    chk("mid_rst_c_out", res_c_out, 0);
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_alu", {alu_oper, alu_a, alu_b, alu_c_in}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (res_valid || !req_ready || alu_a != 0) seen++;
      end
      chk("post_rst_idle", seen, 0);
    end
    chk("post_rst_res", res, 0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) a = 32'hFFFF_FFFF;
      if (i % 8 == 1) b = 32'h0;
      run_txn(3'($urandom_range(0, 7)), a, b, 1'($urandom_range(0, 1)), i % 3);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=%0d exp=%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
